eth_tx_frame_arb: RTL

ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

---
 rtl/eth_tx_arb_pkg.sv | 14 +
 rtl/eth_tx_arb_rr_sel.sv | 30 +++
 rtl/eth_tx_frame_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the 10G TX frame arbiter.
package eth_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // A port index needs at least one bit even for a degenerate single-port build.
  function automatic int idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arb_rr_sel.sv
// Round-robin picker: first requesting port at or after ptr, wrapping modulo PORTS.
module eth_tx_arb_rr_sel
  import eth_tx_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             found
);

  logic [IDX_W:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(PORTS)) idx = idx - (IDX_W+1)'(PORTS);
      if (!found && req[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding several AXI-Stream TX sources into one MAC.
module eth_tx_frame_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic [PORTS-1:0]              port_enable,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_port,
  output logic                          frame_done
);

  localparam int IDX_W = idx_width(PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_port_q, grant_port_d;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             busy;
  logic             src_valid;
  logic             last_xfer;

  eth_tx_arb_rr_sel #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req   (s_axis_tvalid & port_enable),
    .ptr   (rr_ptr_q),
    .sel   (sel),
    .found (found)
  );

  assign busy = (state_q == BUSY);

  // Zero-latency path from the granted source to the MAC.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tuser = '0;
    m_axis_tlast = 1'b0;
    src_valid    = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (IDX_W'(i) == grant_port_q) begin
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        m_axis_tlast     = s_axis_tlast[i];
        src_valid        = s_axis_tvalid[i];
        s_axis_tready[i] = busy & m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = busy & src_valid;
  assign last_xfer     = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign frame_done    = last_xfer;
  assign grant_valid   = busy;
  assign grant_port    = grant_port_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_port_d = grant_port_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_port_d = sel;
        end
      end
      BUSY: begin
        // Only the closing beat releases the grant; enable changes never cut a frame.
        if (last_xfer) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_port_q == IDX_W'(PORTS-1)) ? '0 : grant_port_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_port_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_port_q <= grant_port_d;
    end
  end

endmodule
